lc3_writeback: RTL and testbench

//  LC3 writeback stage; sits directly downstream of execute (and memaccess).

---
 rtl/lc3_writeback.sv | 69 ++++++
 tb/tb_lc3_writeback.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_writeback.sv
// rtl/lc3_writeback.sv - LC3 writeback stage: result select, 8x16 register file, NZP status
module lc3_writeback #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable_writeback,
  input  logic [1:0]                  W_Control,
  input  logic [DATA_W-1:0]           aluout,
  input  logic [DATA_W-1:0]           pcout,
  input  logic [DATA_W-1:0]           memout,
  input  logic [DATA_W-1:0]           npc,
  input  logic [$clog2(NUM_REGS)-1:0] dr,
  input  logic [$clog2(NUM_REGS)-1:0] sr1,
  input  logic [$clog2(NUM_REGS)-1:0] sr2,
  output logic [DATA_W-1:0]           VSR1,
  output logic [DATA_W-1:0]           VSR2,
  output logic [2:0]                  psr,
  output logic                        wb_done
);

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] wdata;
  logic [2:0]        wdata_nzp;
  logic              do_write;

  always_comb begin
    wdata = aluout;
    case (W_Control)
      2'd0:    wdata = aluout;
      2'd1:    wdata = pcout;
      2'd2:    wdata = memout;
      2'd3:    wdata = npc;
      default: wdata = aluout;
    endcase
  end

  // Sign bit takes precedence, so exactly one flag is ever set after a write.
  always_comb begin
    wdata_nzp = 3'b001;
    if (wdata[DATA_W-1])
      wdata_nzp = 3'b100;
    else if (wdata == '0)
      wdata_nzp = 3'b010;
  end

  assign do_write = enable_writeback;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
      psr     <= 3'b000;
      wb_done <= 1'b0;
    end else if (do_write) begin
      rf[dr]  <= wdata;
      psr     <= wdata_nzp;
      wb_done <= 1'b1;
    end else begin
      wb_done <= 1'b0;
    end
  end

  // Unbypassed reads: a same-cycle write to the read index shows up next cycle.
  assign VSR1 = rf[sr1];
  assign VSR2 = rf[sr2];

endmodule

// File: tb/tb_lc3_writeback.sv
// tb/tb_lc3_writeback.sv - scoreboard bench for lc3_writeback
module tb_lc3_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_writeback;
  logic [1:0]  W_Control;
  logic [15:0] aluout, pcout, memout, npc;
  logic [2:0]  dr, sr1, sr2;
  logic [15:0] VSR1, VSR2;
  logic [2:0]  psr;
  logic        wb_done;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [2:0]  dr;
    logic [15:0] data;
    logic [2:0]  nzp;
  } wb_exp_t;

  wb_exp_t     sb_q[$];
  logic [15:0] model_rf [8];
  logic [2:0]  last_psr;

  always #5 clock = ~clock;

  lc3_writeback dut (
    .clock(clock), .reset(reset), .enable_writeback(enable_writeback),
    .W_Control(W_Control), .aluout(aluout), .pcout(pcout), .memout(memout),
    .npc(npc), .dr(dr), .sr1(sr1), .sr2(sr2), .VSR1(VSR1), .VSR2(VSR2),
    .psr(psr), .wb_done(wb_done)
  );

  function automatic logic [2:0] ref_nzp(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Drives one write with distinct junk on the unselected sources, and queues the expectation.
  task automatic drive_write(input logic [1:0] sel, input logic [15:0] val, input logic [2:0] d);
    wb_exp_t e;
    aluout = 16'($urandom); pcout = 16'($urandom);
    memout = 16'($urandom); npc   = 16'($urandom);
    case (sel)
      2'd0: aluout = val;
      2'd1: pcout  = val;
      2'd2: memout = val;
      default: npc = val;
    endcase
    W_Control = sel;
    dr = d;
    enable_writeback = 1'b1;
    e.dr = d; e.data = val; e.nzp = ref_nzp(val);
    sb_q.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enable_writeback = 1'b0;
    tick; tick;
    reset = 1'b0;
    for (int r = 0; r < 8; r++) model_rf[r] = 16'h0000;
    last_psr = 3'b000;
    for (int r = 0; r < 8; r++) begin
      sr1 = 3'(r); sr2 = 3'(7 - r);
      #1;
      tests_run++;
      if (VSR1 !== 16'h0000) begin
        tests_failed++; $display("FAIL reset_vsr1 r=%0d got=%h exp=0000", r, VSR1);
      end
      tests_run++;
      if (VSR2 !== 16'h0000) begin
        tests_failed++; $display("FAIL reset_vsr2 r=%0d got=%h exp=0000", 7 - r, VSR2);
      end
    end
    tests_run++;
    if (psr !== 3'b000) begin tests_failed++; $display("FAIL reset_psr got=%b exp=000", psr); end
    tests_run++;
    if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_done got=%b exp=0", wb_done); end
  endtask

  task automatic test_write_alu;
    wb_exp_t e;
    drive_write(2'd0, 16'h8000, 3'd3);
    tick;
    enable_writeback = 1'b0;
    e = sb_q.pop_front();
    model_rf[e.dr] = e.data; last_psr = e.nzp;
    sr1 = e.dr;
    #1;
    tests_run++;
    if (VSR1 !== e.data) begin tests_failed++; $display("FAIL alu_vsr1 got=%h exp=%h", VSR1, e.data); end
    tests_run++;
    if (psr !== 3'b100) begin tests_failed++; $display("FAIL alu_psr got=%b exp=100", psr); end
    tests_run++;
    if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL alu_wb_done got=%b exp=1", wb_done); end
    tick;
    tests_run++;
    if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL alu_wb_done_pulse got=%b exp=0", wb_done); end
  endtask

  task automatic test_mem_pc_npc;
    wb_exp_t e;
    logic [1:0]  sels [3] = '{2'd2, 2'd1, 2'd3};
    logic [15:0] vals [3] = '{16'h0000, 16'h3005, 16'hC0DE};
    logic [2:0]  dsts [3] = '{3'd7, 3'd7, 3'd5};
    for (int i = 0; i < 3; i++) begin
      drive_write(sels[i], vals[i], dsts[i]);
      tick;
      enable_writeback = 1'b0;
      e = sb_q.pop_front();
      model_rf[e.dr] = e.data; last_psr = e.nzp;
      sr2 = e.dr;
      #1;
      tests_run++;
      if (VSR2 !== e.data) begin tests_failed++; $display("FAIL sel%0d_vsr2 got=%h exp=%h", sels[i], VSR2, e.data); end
      tests_run++;
      if (psr !== e.nzp) begin tests_failed++; $display("FAIL sel%0d_psr got=%b exp=%b", sels[i], psr, e.nzp); end
    end
  endtask

  task automatic test_hold;
    enable_writeback = 1'b0;
    W_Control = 2'd0; dr = 3'd1; aluout = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests_run++;
      if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL hold_wb_done cyc=%0d got=%b exp=0", i, wb_done); end
    end
    sr1 = 3'd1;
    #1;
    tests_run++;
    if (VSR1 !== model_rf[1]) begin tests_failed++; $display("FAIL hold_rf1 got=%h exp=%h", VSR1, model_rf[1]); end
    tests_run++;
    if (psr !== last_psr) begin tests_failed++; $display("FAIL hold_psr got=%b exp=%b", psr, last_psr); end
  endtask

  task automatic test_collision;
    wb_exp_t e;
    drive_write(2'd0, 16'h1111, 3'd2);
    tick;
    e = sb_q.pop_front();
    model_rf[e.dr] = e.data; last_psr = e.nzp;
    drive_write(2'd0, 16'h2222, 3'd2);
    sr2 = 3'd2;
    #1;
    tests_run++;
    if (VSR2 !== 16'h1111) begin tests_failed++; $display("FAIL collision_old got=%h exp=1111", VSR2); end
    tick;
    enable_writeback = 1'b0;
    e = sb_q.pop_front();
    model_rf[e.dr] = e.data; last_psr = e.nzp;
    tests_run++;
    if (VSR2 !== 16'h2222) begin tests_failed++; $display("FAIL collision_new got=%h exp=2222", VSR2); end
  endtask

  task automatic test_reset_priority;
    wb_exp_t e;
    drive_write(2'd0, 16'h4444, 3'd4);
    tick;
    e = sb_q.pop_front();
    model_rf[e.dr] = e.data; last_psr = e.nzp;
    aluout = 16'h7777; dr = 3'd4; W_Control = 2'd0;
    enable_writeback = 1'b1;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    enable_writeback = 1'b0;
    for (int r = 0; r < 8; r++) model_rf[r] = 16'h0000;
    last_psr = 3'b000;
    sr1 = 3'd4; sr2 = 3'd2;
    #1;
    tests_run++;
    if (VSR1 !== 16'h0000) begin tests_failed++; $display("FAIL rstpri_rf4 got=%h exp=0000", VSR1); end
    tests_run++;
    if (VSR2 !== 16'h0000) begin tests_failed++; $display("FAIL rstpri_rf2 got=%h exp=0000", VSR2); end
    tests_run++;
    if (psr !== 3'b000) begin tests_failed++; $display("FAIL rstpri_psr got=%b exp=000", psr); end
    tests_run++;
    if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL rstpri_wb_done got=%b exp=0", wb_done); end
  endtask

  task automatic test_back_to_back;
    wb_exp_t e;
    logic [15:0] v;
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0: v = 16'h0000;
        1: v = 16'h8000 | 16'($urandom);
        default: v = 16'($urandom_range(1, 16'h7FFF));
      endcase
      drive_write(2'($urandom_range(0, 3)), v, 3'($urandom_range(0, 7)));
      tick;
      e = sb_q.pop_front();
      model_rf[e.dr] = e.data; last_psr = e.nzp;
      sr1 = e.dr;
      sr2 = 3'($urandom_range(0, 7));
      #1;
      tests_run++;
      if (VSR1 !== e.data) begin tests_failed++; $display("FAIL b2b_vsr1 i=%0d got=%h exp=%h", i, VSR1, e.data); end
      tests_run++;
      if (VSR2 !== model_rf[sr2]) begin tests_failed++; $display("FAIL b2b_vsr2 i=%0d got=%h exp=%h", i, VSR2, model_rf[sr2]); end
      tests_run++;
      if (psr !== e.nzp) begin tests_failed++; $display("FAIL b2b_psr i=%0d got=%b exp=%b", i, psr, e.nzp); end
      tests_run++;
      if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_wb_done i=%0d got=%b exp=1", i, wb_done); end
    end
    enable_writeback = 1'b0;
    tick;
    tests_run++;
    if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle_wb_done got=%b exp=0", wb_done); end
    for (int r = 0; r < 8; r++) begin
      sr1 = 3'(r);
      #1;
      tests_run++;
      if (VSR1 !== model_rf[r]) begin tests_failed++; $display("FAIL b2b_final_rf%0d got=%h exp=%h", r, VSR1, model_rf[r]); end
    end
    tests_run++;
    if (sb_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable_writeback = 1'b0; W_Control = 2'd0;
    aluout = '0; pcout = '0; memout = '0; npc = '0;
    dr = '0; sr1 = '0; sr2 = '0;
    test_reset;
    test_write_alu;
    test_mem_pc_npc;
    test_hold;
    test_collision;
    test_reset_priority;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
